sram_like_arbiter: RTL and testbench

//  Two-to-one arbiter for the sram-like bus, feeding the single AXI bridge.

---
 rtl/sram_like_arbiter_pkg.sv | 25 ++
 rtl/sram_like_arbiter_rr_arb2.sv | 26 ++
 rtl/sram_like_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_pkg
// Purpose  : Shared state encodings, owner codes and size constant for the
//            sram-like bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_like_arbiter_pkg;

    // Arbiter state: arbitration bubble, address handshake, data wait
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } st_e;

    // Owner encoding, also used as the index of the port in req/gnt vectors
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // The instruction port always fetches whole words
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage : sram_like_arbiter_pkg
`default_nettype wire

// File: rtl/sram_like_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin picker. Pure combinational; on contention
//            the port that did not own the last completed grant wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // One-hot grant: single requester wins outright, a tie goes to !last
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Purpose  : Two-to-one arbiter (inst read-only port, data read/write port)
//            in front of a single sram-like bridge. One transaction in flight,
//            round-robin on contention, handshakes routed to the owner only.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    // instruction port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    // data port
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    // bridge side
    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok
);

    st_e  st_q,   st_d;
    logic own_q,  own_d;
    logic last_q, last_d;

    logic [1:0] w_gnt;
    logic       w_owner_req;

    rr_arb2 u_rr_arb2 (
        .req_i  ({d_req, i_req}),
        .last_i (last_q),
        .gnt_o  (w_gnt)
    );

    assign w_owner_req = (own_q == OWN_DATA) ? d_req : i_req;

    // State, owner and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            own_q  <= OWN_INST;
            last_q <= OWN_INST;
        end else begin
            st_q   <= st_d;
            own_q  <= own_d;
            last_q <= last_d;
        end
    end

    // Next-state logic and combinational decode of all bus outputs
    always_comb begin
        st_d      = st_q;
        own_d     = own_q;
        last_d    = last_q;
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_size    = 2'b00;
        m_addr    = '0;
        m_wdata   = '0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_rdata   = '0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = '0;

        case (st_q)
            ST_IDLE: begin
                if (|w_gnt) begin
                    own_d = w_gnt[1] ? OWN_DATA : OWN_INST;
                    st_d  = ST_ADDR;
                end
            end

            ST_ADDR: begin
                m_req = w_owner_req;
                if (own_q == OWN_DATA) begin
                    m_wr    = d_wr;
                    m_size  = d_size;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                end else begin
                    m_wr    = 1'b0;
                    m_size  = SIZE_WORD;
                    m_addr  = i_addr;
                end
                // A dropped request before acceptance is a flush: back to
                // arbitration without touching the round-robin history.
                if (!w_owner_req) begin
                    st_d = ST_IDLE;
                end else if (m_addr_ok) begin
                    if (own_q == OWN_DATA) d_addr_ok = 1'b1;
                    else                   i_addr_ok = 1'b1;
                    st_d = ST_DATA;
                end
            end

            ST_DATA: begin
                // Owner's req is ignored here: an accepted access must finish
                if (m_data_ok) begin
                    if (own_q == OWN_DATA) begin
                        d_data_ok = 1'b1;
                        d_rdata   = m_rdata;
                    end else begin
                        i_data_ok = 1'b1;
                        i_rdata   = m_rdata;
                    end
                    last_d = own_q;
                    st_d   = ST_IDLE;
                end
            end

            default: st_d = ST_IDLE;
        endcase
    end

endmodule : sram_like_arbiter
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Purpose  : Directed scoreboard bench for sram_like_arbiter. The stimulus
//            process plays both masters and the bridge; a monitor pops
//            expected handshakes whenever the DUT pulses an *_ok.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_addr_ok, i_data_ok;
    logic        d_req = 1'b0, d_wr = 1'b0;
    logic [1:0]  d_size = 2'b10;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_addr_ok, d_data_ok;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;

    sram_like_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } aexp_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } dexp_t;

    aexp_t aq[$];
    dexp_t dq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int i_aok_cnt = 0, i_dok_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every *_ok pulse must match the head of its expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            if (i_addr_ok) i_aok_cnt++;
            if (i_data_ok) i_dok_cnt++;
            if (i_addr_ok || d_addr_ok) begin
                if (aq.size() == 0) begin
                    chk("addr_ok_unexpected", {30'b0, d_addr_ok, i_addr_ok}, 32'd0);
                end else begin
                    aexp_t e;
                    e = aq.pop_front();
                    chk("addr_ok_port", {30'b0, d_addr_ok, i_addr_ok}, e.port ? 32'd2 : 32'd1);
                    chk("m_addr", m_addr, e.addr);
                    chk("m_wr", {31'b0, m_wr}, {31'b0, e.wr});
                    chk("m_size", {30'b0, m_size}, {30'b0, e.size});
                    chk("m_wdata", m_wdata, e.wdata);
                end
            end
            if (i_data_ok || d_data_ok) begin
                if (dq.size() == 0) begin
                    chk("data_ok_unexpected", {30'b0, d_data_ok, i_data_ok}, 32'd0);
                end else begin
                    dexp_t e;
                    e = dq.pop_front();
                    chk("data_ok_port", {30'b0, d_data_ok, i_data_ok}, e.port ? 32'd2 : 32'd1);
                    chk("owner_rdata", e.port ? d_rdata : i_rdata, e.rdata);
                    chk("other_rdata", e.port ? i_rdata : d_rdata, 32'd0);
                end
            end
        end
    end

    // Wait (bounded) for the bridge request to appear
    task automatic wait_req();
        int k = 0;
        while (!m_req && k < 8) begin
            tick();
            k++;
        end
        chk("m_req_rise", {31'b0, m_req}, 32'd1);
    endtask

    // Bridge model for one transaction; expectations pushed as it is issued
    task automatic serve(input logic port, input logic [31:0] addr, input logic wr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int wait_n, input logic keep);
        wait_req();
        for (int j = 0; j < wait_n; j++) begin
            chk("stall_m_req", {31'b0, m_req}, 32'd1);
            chk("stall_m_addr", m_addr, addr);
            tick();
        end
        aq.push_back('{port, addr, wr, size, wdata});
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        if (!keep) begin
            if (port) d_req = 1'b0;
            else      i_req = 1'b0;
        end
        dq.push_back('{port, rdata});
        m_rdata   = rdata;
        m_data_ok = 1'b1;
        tick();
        m_data_ok = 1'b0;
        m_rdata   = '0;
    endtask

    initial begin
        int a0, d0;
        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_m_req", {31'b0, m_req}, 32'd0);
        chk("rst_m_wr", {31'b0, m_wr}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_oks", {28'b0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single data read, one arbitration bubble
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h0000_1000;
        #1;
        chk("t1_bubble_m_req", {31'b0, m_req}, 32'd0);
        tick();
        chk("t1_m_req", {31'b0, m_req}, 32'd1);
        chk("t1_m_addr", m_addr, 32'h0000_1000);
        serve(1'b1, 32'h0000_1000, 1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        tick();

        // 2: contention from a fresh reset, grants alternate D,I,D,I
        rst = 1'b1; tick(); rst = 1'b0;
        i_addr = 32'hBFC0_0010; d_addr = 32'h0000_3000; d_wdata = 32'h0;
        i_req = 1'b1; d_req = 1'b1;
        serve(1'b1, 32'h0000_3000, 1'b0, 2'b10, 32'h0, 32'h1111_0001, 0, 1'b1);
        serve(1'b0, 32'hBFC0_0010, 1'b0, 2'b10, 32'h0, 32'h2222_0002, 0, 1'b1);
        serve(1'b1, 32'h0000_3000, 1'b0, 2'b10, 32'h0, 32'h3333_0003, 0, 1'b0);
        serve(1'b0, 32'hBFC0_0010, 1'b0, 2'b10, 32'h0, 32'h4444_0004, 0, 1'b0);
        tick();

        // 3: inst read with five stalled address cycles
        a0 = i_aok_cnt; d0 = i_dok_cnt;
        i_addr = 32'hBFC0_0000; i_req = 1'b1;
        serve(1'b0, 32'hBFC0_0000, 1'b0, 2'b10, 32'h0, 32'h3C08_BFC0, 5, 1'b0);
        tick();
        chk("t3_one_i_addr_ok", i_aok_cnt - a0, 32'd1);
        chk("t3_one_i_data_ok", i_dok_cnt - d0, 32'd1);

        // 4: flush in ADDR, late m_addr_ok ignored, then a fresh fetch
        i_addr = 32'hBFC0_0300; i_req = 1'b1;
        tick();
        chk("t4_m_req", {31'b0, m_req}, 32'd1);
        tick();
        i_req = 1'b0;
        #1;
        chk("t4_flush_m_req", {31'b0, m_req}, 32'd0);
        tick(); tick();
        m_addr_ok = 1'b1;
        #1;
        chk("t4_no_i_addr_ok", {31'b0, i_addr_ok}, 32'd0);
        tick();
        m_addr_ok = 1'b0;
        i_addr = 32'hBFC0_0380; i_req = 1'b1;
        serve(1'b0, 32'hBFC0_0380, 1'b0, 2'b10, 32'h0, 32'h0000_0380, 0, 1'b0);
        tick();

        // 5: byte write, rdata passes through on the ack
        d_wr = 1'b1; d_size = 2'b00; d_addr = 32'h0000_2003; d_wdata = 32'h0000_00AB;
        d_req = 1'b1;
        serve(1'b1, 32'h0000_2003, 1'b1, 2'b00, 32'h0000_00AB, 32'h1234_5678, 1, 1'b0);
        tick();

        // 6: reset in DATA, stray m_data_ok afterwards is ignored
        d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h0000_4000; d_wdata = '0;
        d_req = 1'b1;
        wait_req();
        aq.push_back('{1'b1, 32'h0000_4000, 1'b0, 2'b10, 32'h0});
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        d_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rdata = 32'h5555_5555; m_data_ok = 1'b1;
        #1;
        chk("t6_data_oks", {30'b0, i_data_ok, d_data_ok}, 32'd0);
        chk("t6_m_req", {31'b0, m_req}, 32'd0);
        tick();
        m_data_ok = 1'b0; m_rdata = '0;
        tick(); tick();

        chk("addr_queue_drained", aq.size(), 32'd0);
        chk("data_queue_drained", dq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected $finish");
        $fatal(1);
    end

endmodule : tb_sram_like_arbiter
`default_nettype wire
